friscv_icache_line_fetcher: RTL and testbench
=============================================

# friscv_icache_line_fetcher

Refill and invalidation engine for the instruction cache storage. On a lookup miss it fetches one full cache line from memory over an AXI4 read burst, assembles the beats, and writes the line into the cache line array through its write port. On a flush request (FENCE.i) it walks every cache index and clears each line's set bit.

## Interface

- ADDR_W, 32, address width
- XLEN, 32, AXI data width and instruction width
- CACHE_LINE_W, 128, line payload width in bits; BEATS = CACHE_LINE_W/XLEN, power of two ≥ 2
- CACHE_DEPTH, 512, number of cache lines; INDEX_W = $clog2(CACHE_DEPTH)
- AXI_ID_W, 8, AXI ID width
- AXI_ID, 8'h20, constant ID driven on arid and expected on rid

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset, same effect as aresetn
- miss_valid  in  1  refill request
- miss_ready  out  1  refill request accepted when miss_valid & miss_ready
- miss_addr  in  ADDR_W  address that missed
- flush_req  in  1  level request to invalidate the whole cache
- flush_done  out  1  one-cycle pulse on the last invalidation write
- fill_done  out  1  one-cycle pulse when a refill completes, written or not
- fill_err  out  1  one-cycle pulse, with fill_done, when any beat had rresp != 0
- arvalid  out  1, arready  in  1, araddr  out  ADDR_W, arlen  out  8, arsize  out  3, arburst  out  2, arid  out  AXI_ID_W, arprot  out  3: AXI4 read address channel
- rvalid  in  1, rready  out  1, rid  in  AXI_ID_W, rresp  in  2, rdata  in  XLEN, rlast  in  1: AXI4 read data channel
- cache_wen  out  1  cache write enable
- cache_waddr  out  ADDR_W  cache write address; the cache takes the index and tag from it
- cache_wdata  out  CACHE_LINE_W  line payload
- cache_flush  out  1  high when the write invalidates the line (clears its set bit)

## Operation

- FSM states: IDLE, FLUSH, REQ, FILL, WRITE.
- IDLE: miss_ready = ~flush_req. flush_req has priority over miss_valid; if asserted, go to FLUSH with the index counter at 0. Otherwise, on handshake, latch miss_addr and go to REQ.
- FLUSH: every cycle, cache_wen = 1, cache_flush = 1, cache_wdata = 0, and cache_waddr = counter placed at the index field (bits [log2(BEATS) +: INDEX_W]) with other bits 0. The counter increments each cycle. When counter = CACHE_DEPTH-1, pulse flush_done and go to IDLE.
- REQ: arvalid = 1 with constant fields until arready, then go to FILL.
  - araddr = latched address with the low $clog2(CACHE_LINE_W/8) bits cleared.
  - arlen = BEATS-1, arsize = $clog2(XLEN/8), arburst = INCR (2'b01), arid = AXI_ID, arprot = 3'b100.
- FILL: rready = 1. Beat k (0-based beat counter) is stored in cache_wdata[k*XLEN +: XLEN]. Any rresp != 0 sets a sticky error flag. Beats with rid != AXI_ID are ignored: not counted, not stored. On beat BEATS-1, go to WRITE. rlast is not used for termination.
- WRITE: one cycle. cache_wen = ~error, cache_flush = 0, cache_waddr = latched miss_addr. Pulse fill_done, and fill_err if error. Clear the error flag and go to IDLE.
- A flush_req arriving during REQ, FILL or WRITE is deferred. It is honored in IDLE after the refill, because the request is level-held.
- Outside FLUSH and WRITE: cache_wen = 0, cache_flush = 0. cache_wdata keeps the assembly buffer.

## Timing

- Reset (aresetn low, or srst high on a clock edge): state IDLE. arvalid, rready, cache_wen, cache_flush, flush_done, fill_done, fill_err = 0. Counters, error flag, cache_waddr, cache_wdata, araddr = 0. miss_ready = ~flush_req.
- Reset mid-burst abandons the transaction without a cache write. Draining outstanding beats is the interconnect's concern.
- Miss accepted at cycle T: arvalid high from T+1.
- Last data beat accepted at cycle L: cache_wen and fill_done at L+1, miss_ready high again at L+2.
- Minimum refill with arready high and rvalid back-to-back: accept + 1 (REQ) + BEATS (FILL) + 1 (WRITE) cycles.
- Flush sampled at T: cache_wen high T+1 to T+CACHE_DEPTH, flush_done at T+CACHE_DEPTH, miss_ready at T+CACHE_DEPTH+1 if flush_req has dropped.
- rvalid stalls and arready backpressure only extend REQ/FILL. No timeout.

## Test plan

- Refill, defaults: miss_addr 0x0000_1234, memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> araddr 0x0000_1230, arlen 3, arsize 2, arburst 1. One cache_wen with cache_waddr 0x0000_1234 and cache_wdata 0x44444444_33333333_22222222_11111111. fill_done one cycle.
- Backpressure: arready low 5 cycles, random rvalid gaps -> arvalid/araddr stable until handshake. Same line written exactly once. Latency grows by exactly the stall cycles.
- Error beat: rresp=2 on beat 1 -> no cache_wen. fill_done and fill_err pulse together. The next refill writes normally.
- Flush from IDLE, CACHE_DEPTH=8: 8 consecutive writes with cache_flush=1 at indices 0..7, flush_done on the 8th, miss_ready low throughout.
- Flush during FILL: flush_req raised at beat 1 -> refill completes and is written, then the flush walk starts next cycle after IDLE. A miss_valid held high is not accepted until the flush is done.
- Async reset at beat 2 -> all outputs reset immediately. After release, a new miss refills correctly, with no stale beats in cache_wdata.

Source files
------------

// File: rtl/friscv_icache_line_fetcher.sv
// Instruction cache refill and invalidation engine: fetches one line over an AXI4 INCR read burst
// and writes it to the line array, or walks every index clearing its set bit on a flush.
module friscv_icache_line_fetcher #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CACHE_LINE_W = 128,
  parameter int unsigned CACHE_DEPTH  = 512,
  parameter int unsigned AXI_ID_W     = 8,
  parameter logic [AXI_ID_W-1:0] AXI_ID = 8'h20
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic                    miss_valid,
  output logic                    miss_ready,
  input  logic [ADDR_W-1:0]       miss_addr,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic                    fill_done,
  output logic                    fill_err,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [AXI_ID_W-1:0]     arid,
  output logic [2:0]              arprot,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [AXI_ID_W-1:0]     rid,
  input  logic [1:0]              rresp,
  input  logic [XLEN-1:0]         rdata,
  input  logic                    rlast,
  output logic                    cache_wen,
  output logic [ADDR_W-1:0]       cache_waddr,
  output logic [CACHE_LINE_W-1:0] cache_wdata,
  output logic                    cache_flush
);

  localparam int unsigned BEATS    = CACHE_LINE_W / XLEN;
  localparam int unsigned BEAT_W   = $clog2(BEATS);
  localparam int unsigned INDEX_W  = $clog2(CACHE_DEPTH);
  localparam int unsigned OFFSET_W = $clog2(CACHE_LINE_W / 8);

  localparam logic [INDEX_W-1:0] IdxLast  = INDEX_W'(CACHE_DEPTH - 1);
  localparam logic [BEAT_W-1:0]  BeatLast = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {StIdle, StFlush, StReq, StFill, StWrite} state_e;

  state_e              state_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;

  logic [INDEX_W-1:0]  idx_nxt;
  logic [BEAT_W-1:0]   beat_nxt;
  logic                beat_ok;
  logic                beat_err;
  logic                unused_rlast;

  assign idx_nxt  = idx_q + 1'b1;
  assign beat_nxt = beat_q + 1'b1;
  // Beats tagged with a foreign ID belong to someone else and are dropped entirely.
  assign beat_ok  = rvalid && (rid == AXI_ID);
  assign beat_err = err_q || (rresp != 2'b00);
  // The burst length is fixed, so the beat counter alone ends the fill.
  assign unused_rlast = rlast;

  assign miss_ready = (state_q == StIdle) && !flush_req;
  assign arlen      = 8'(BEATS - 1);
  assign arsize     = 3'($clog2(XLEN / 8));
  assign arburst    = 2'b01;
  assign arid       = AXI_ID;
  assign arprot     = 3'b100;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      cache_wen   <= 1'b0;
      cache_flush <= 1'b0;
      cache_waddr <= '0;
      cache_wdata <= '0;
      flush_done  <= 1'b0;
      fill_done   <= 1'b0;
      fill_err    <= 1'b0;
    end else if (srst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      cache_wen   <= 1'b0;
      cache_flush <= 1'b0;
      cache_waddr <= '0;
      cache_wdata <= '0;
      flush_done  <= 1'b0;
      fill_done   <= 1'b0;
      fill_err    <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cache_wen   <= 1'b0;
          cache_flush <= 1'b0;
          if (flush_req) begin
            state_q     <= StFlush;
            idx_q       <= '0;
            cache_wen   <= 1'b1;
            cache_flush <= 1'b1;
            cache_waddr <= '0;
            cache_wdata <= '0;
          end else if (miss_valid) begin
            state_q <= StReq;
            addr_q  <= miss_addr;
            araddr  <= {miss_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            arvalid <= 1'b1;
          end
        end
        StFlush: begin
          if (idx_q == IdxLast) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cache_wen   <= 1'b0;
            cache_flush <= 1'b0;
          end else begin
            idx_q       <= idx_nxt;
            cache_waddr <= ADDR_W'(idx_nxt) << BEAT_W;
            flush_done  <= (idx_nxt == IdxLast);
          end
        end
        StReq: begin
          if (arready) begin
            state_q <= StFill;
            arvalid <= 1'b0;
            rready  <= 1'b1;
            beat_q  <= '0;
          end
        end
        StFill: begin
          if (beat_ok) begin
            cache_wdata[beat_q*XLEN +: XLEN] <= rdata;
            beat_q <= beat_nxt;
            if (rresp != 2'b00) begin
              err_q <= 1'b1;
            end
            if (beat_q == BeatLast) begin
              state_q     <= StWrite;
              rready      <= 1'b0;
              cache_wen   <= !beat_err;
              cache_flush <= 1'b0;
              cache_waddr <= addr_q;
              fill_done   <= 1'b1;
              fill_err    <= beat_err;
            end
          end
        end
        StWrite: begin
          state_q   <= StIdle;
          cache_wen <= 1'b0;
          err_q     <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_icache_line_fetcher.sv
// Scoreboard bench for the icache line fetcher: expected cache writes and fill results are queued
// when stimulus is driven and checked by a monitor as the DUT produces them.
module tb_friscv_icache_line_fetcher;

  localparam int BEATS = 4;
  localparam int DEPTH = 8;
  localparam logic [7:0] ID = 8'h20;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         flush;
  } wr_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         srst = 1'b0;
  logic         miss_valid = 1'b0;
  logic         miss_ready;
  logic [31:0]  miss_addr = '0;
  logic         flush_req = 1'b0;
  logic         flush_done, fill_done, fill_err;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [7:0]   arid;
  logic [2:0]   arprot;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [7:0]   rid = '0;
  logic [1:0]   rresp = '0;
  logic [31:0]  rdata = '0;
  logic         rlast = 1'b0;
  logic         cache_wen;
  logic [31:0]  cache_waddr;
  logic [127:0] cache_wdata;
  logic         cache_flush;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  r_hs = 0;
  wr_t wq[$];
  bit  fq[$];
  wr_t mon_e;
  bit  mon_f;

  friscv_icache_line_fetcher #(
    .CACHE_DEPTH(DEPTH)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .srst        (srst),
    .miss_valid  (miss_valid),
    .miss_ready  (miss_ready),
    .miss_addr   (miss_addr),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .fill_done   (fill_done),
    .fill_err    (fill_err),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arid        (arid),
    .arprot      (arprot),
    .rvalid      (rvalid),
    .rready      (rready),
    .rid         (rid),
    .rresp       (rresp),
    .rdata       (rdata),
    .rlast       (rlast),
    .cache_wen   (cache_wen),
    .cache_waddr (cache_waddr),
    .cache_wdata (cache_wdata),
    .cache_flush (cache_flush)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (rvalid && rready) r_hs <= r_hs + 1;
  end

  // Scoreboard monitor: every cache write and fill completion must match the queued expectation.
  always @(negedge aclk) begin
    if (cache_wen) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL cache_write unexpected: got addr=%h flush=%b, want no write",
                 cache_waddr, cache_flush);
      end else begin
        mon_e = wq.pop_front();
        if ({cache_waddr, cache_wdata, cache_flush} !== {mon_e.addr, mon_e.data, mon_e.flush}) begin
          bad++;
          $display("FAIL cache_write got addr=%h data=%h flush=%b want addr=%h data=%h flush=%b",
                   cache_waddr, cache_wdata, cache_flush, mon_e.addr, mon_e.data, mon_e.flush);
        end
      end
    end
    if (fill_done) begin
      total++;
      if (fq.size() == 0) begin
        bad++;
        $display("FAIL fill_done unexpected: got 1 want 0");
      end else begin
        mon_f = fq.pop_front();
        if (fill_err !== mon_f) begin
          bad++;
          $display("FAIL fill_err got %b want %b", fill_err, mon_f);
        end
      end
    end else if (fill_err) begin
      total++;
      bad++;
      $display("FAIL fill_err_alone got fill_err=1 want 0 without fill_done");
    end
  end

  // Drives one refill through the AXI slave side; queues the expected write and fill result.
  task automatic drive_refill(input logic [31:0] addr, input logic [127:0] line,
                              input int err_beat, input int ar_stall, input int gap_max,
                              input int foreign_at, output int lat, output int extra,
                              output logic [31:0] ar_seen, output bit ar_ok);
    int  t0, n, k, g, fa;
    wr_t e;
    ar_ok = 1'b1;
    extra = ar_stall;
    fa = foreign_at;
    e.addr = addr;
    e.data = line;
    e.flush = 1'b0;
    if (err_beat < 0) wq.push_back(e);
    fq.push_back(err_beat >= 0);
    @(negedge aclk);
    miss_valid = 1'b1;
    miss_addr = addr;
    n = 0;
    while (miss_ready !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    t0 = cyc;
    @(negedge aclk);
    miss_valid = 1'b0;
    ar_seen = araddr;
    for (int i = 0; i < ar_stall; i++) begin
      if (arvalid !== 1'b1 || araddr !== ar_seen) ar_ok = 1'b0;
      @(negedge aclk);
    end
    if (arvalid !== 1'b1 || araddr !== ar_seen) ar_ok = 1'b0;
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    if (arvalid !== 1'b0) ar_ok = 1'b0;
    k = 0;
    while (k < BEATS) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      extra += g;
      rvalid = 1'b0;
      repeat (g) @(negedge aclk);
      if (k == fa) begin
        rvalid = 1'b1;
        rid = 8'h05;
        rdata = 32'hdead_beef;
        rresp = 2'd0;
        rlast = 1'b0;
        @(negedge aclk);
        extra++;
        fa = -1;
      end
      rvalid = 1'b1;
      rid = ID;
      rdata = line[k*32 +: 32];
      rresp = (k == err_beat) ? 2'd2 : 2'd0;
      rlast = (k == BEATS - 1);
      n = 0;
      while (rready !== 1'b1 && n < 100) begin
        @(negedge aclk);
        n++;
      end
      @(negedge aclk);
      k++;
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'd0;
    n = 0;
    while (fill_done !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    lat = cyc - t0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({arvalid, rready, cache_wen, cache_flush, flush_done, fill_done, fill_err} !== 7'b0 ||
        miss_ready !== 1'b1 || araddr !== 32'h0 || cache_wdata !== 128'h0) begin
      bad++;
      $display("FAIL reset_outputs got ctl=%b miss_ready=%b araddr=%h want all zero, miss_ready=1",
               {arvalid, rready, cache_wen, cache_flush, flush_done, fill_done, fill_err},
               miss_ready, araddr);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    miss_valid = 1'b1;
    miss_addr = 32'h0000_0040;
    @(negedge aclk);
    miss_valid = 1'b0;
    total++;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_0040) begin
      bad++;
      $display("FAIL req_after_accept got arvalid=%b araddr=%h want 1 00000040", arvalid, araddr);
    end
    srst = 1'b1;
    @(negedge aclk);
    srst = 1'b0;
    total++;
    if (arvalid !== 1'b0 || miss_ready !== 1'b1 || araddr !== 32'h0) begin
      bad++;
      $display("FAIL srst got arvalid=%b miss_ready=%b araddr=%h want 0 1 0",
               arvalid, miss_ready, araddr);
    end
  endtask

  task automatic test_refill_basic();
    int lat, extra;
    logic [31:0] ar;
    bit ok;
    drive_refill(32'h0000_1234, 128'h44444444_33333333_22222222_11111111, -1, 0, 0, -1,
                 lat, extra, ar, ok);
    total++;
    if (ar !== 32'h0000_1230) begin
      bad++;
      $display("FAIL araddr got %h want 00001230", ar);
    end
    total++;
    if ({arlen, arsize, arburst, arid, arprot} !== {8'd3, 3'd2, 2'd1, 8'h20, 3'b100}) begin
      bad++;
      $display("FAIL ar_fields got len=%0d size=%0d burst=%0d id=%h prot=%b want 3 2 1 20 100",
               arlen, arsize, arburst, arid, arprot);
    end
    total++;
    if (lat !== 2 + BEATS || !ok) begin
      bad++;
      $display("FAIL basic_latency got %0d (ar_ok=%b) want %0d", lat, ok, 2 + BEATS);
    end
    @(negedge aclk);
    total++;
    if (fill_done !== 1'b0 || cache_wen !== 1'b0 || miss_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_write got fill_done=%b wen=%b miss_ready=%b want 0 0 1",
               fill_done, cache_wen, miss_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat, extra;
    logic [31:0] ar;
    bit ok;
    logic [127:0] line;
    for (int i = 0; i < 2; i++) begin
      line = {$urandom, $urandom, $urandom, $urandom};
      drive_refill(32'h8000_0a5c + 32'(i * 16), line, -1, 5, 3, -1, lat, extra, ar, ok);
      total++;
      if (!ok || ar !== ((32'h8000_0a5c + 32'(i * 16)) & 32'hffff_fff0)) begin
        bad++;
        $display("FAIL ar_stable got ok=%b araddr=%h want stable aligned address", ok, ar);
      end
      total++;
      if (lat !== 2 + BEATS + extra) begin
        bad++;
        $display("FAIL stall_latency got %0d want %0d", lat, 2 + BEATS + extra);
      end
    end
  endtask

  task automatic test_error();
    int lat, extra;
    logic [31:0] ar;
    bit ok;
    drive_refill(32'h0000_2000, 128'hdeadbeef_cafef00d_01234567_89abcdef, 1, 0, 0, -1,
                 lat, extra, ar, ok);
    total++;
    if (fill_err !== 1'b1 || cache_wen !== 1'b0) begin
      bad++;
      $display("FAIL err_write got fill_err=%b wen=%b want 1 0", fill_err, cache_wen);
    end
    drive_refill(32'h0000_2010, 128'h0a0a0a0a_0b0b0b0b_0c0c0c0c_0d0d0d0d, -1, 0, 0, -1,
                 lat, extra, ar, ok);
    total++;
    if (fill_err !== 1'b0 || cache_wen !== 1'b1) begin
      bad++;
      $display("FAIL after_err_write got fill_err=%b wen=%b want 0 1", fill_err, cache_wen);
    end
  endtask

  task automatic test_foreign_id();
    int lat, extra;
    logic [31:0] ar;
    bit ok;
    drive_refill(32'h0000_3008, 128'h5555aaaa_6666bbbb_7777cccc_8888dddd, -1, 0, 0, 2,
                 lat, extra, ar, ok);
    total++;
    if (lat !== 2 + BEATS + extra || extra !== 1) begin
      bad++;
      $display("FAIL foreign_latency got %0d want %0d", lat, 2 + BEATS + 1);
    end
  endtask

  task automatic test_flush_idle();
    wr_t e;
    @(negedge aclk);
    for (int i = 0; i < DEPTH; i++) begin
      e.addr = 32'(i) << 2;
      e.data = '0;
      e.flush = 1'b1;
      wq.push_back(e);
    end
    flush_req = 1'b1;
    #1;
    total++;
    if (miss_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_blocks_miss got miss_ready=%b want 0", miss_ready);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge aclk);
      total++;
      if (cache_wen !== 1'b1 || flush_done !== (i == DEPTH) || miss_ready !== 1'b0) begin
        bad++;
        $display("FAIL flush_walk cycle %0d got wen=%b done=%b miss_ready=%b want 1 %b 0",
                 i, cache_wen, flush_done, miss_ready, i == DEPTH);
      end
      if (i == DEPTH) flush_req = 1'b0;
    end
    @(negedge aclk);
    total++;
    if (miss_ready !== 1'b1 || cache_wen !== 1'b0) begin
      bad++;
      $display("FAIL flush_end got miss_ready=%b wen=%b want 1 0", miss_ready, cache_wen);
    end
  endtask

  task automatic test_flush_during_fill();
    int lat, extra, base, n;
    logic [31:0] ar;
    bit ok;
    wr_t e;
    base = r_hs;
    fork
      drive_refill(32'h0000_5678, 128'h13579bdf_2468ace0_fedcba98_76543210, -1, 0, 0, -1,
                   lat, extra, ar, ok);
      begin
        n = 0;
        while (r_hs < base + 1 && n < 100) begin
          @(negedge aclk);
          n++;
        end
        flush_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          e.addr = 32'(i) << 2;
          e.data = '0;
          e.flush = 1'b1;
          wq.push_back(e);
        end
      end
    join
    total++;
    if (lat !== 2 + BEATS) begin
      bad++;
      $display("FAIL deferred_flush_refill_latency got %0d want %0d", lat, 2 + BEATS);
    end
    miss_valid = 1'b1;
    miss_addr = 32'h0000_7000;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      @(negedge aclk);
      total++;
      if (cache_wen !== (i >= 2) || flush_done !== (i == DEPTH + 1) || miss_ready !== 1'b0 ||
          arvalid !== 1'b0) begin
        bad++;
        $display("FAIL deferred_flush cycle %0d got wen=%b done=%b miss_ready=%b arvalid=%b",
                 i, cache_wen, flush_done, miss_ready, arvalid);
      end
      if (i == DEPTH + 1) flush_req = 1'b0;
    end
    @(negedge aclk);
    total++;
    if (miss_ready !== 1'b1) begin
      bad++;
      $display("FAIL miss_after_flush got miss_ready=%b want 1", miss_ready);
    end
    miss_valid = 1'b0;
  endtask

  task automatic test_async_reset_mid();
    int lat, extra;
    logic [31:0] ar;
    bit ok;
    @(negedge aclk);
    miss_valid = 1'b1;
    miss_addr = 32'h0000_9abc;
    @(negedge aclk);
    miss_valid = 1'b0;
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1;
      rid = ID;
      rdata = 32'hbad0_0000 + 32'(k);
      @(negedge aclk);
    end
    rdata = 32'hbad0_0002;
    #2;
    aresetn = 1'b0;
    #1;
    total++;
    if ({arvalid, rready, cache_wen, cache_flush, fill_done, fill_err, flush_done} !== 7'b0 ||
        cache_wdata !== 128'h0 || cache_waddr !== 32'h0 || miss_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got ctl=%b wdata=%h waddr=%h miss_ready=%b want zeros, 1",
               {arvalid, rready, cache_wen, cache_flush, fill_done, fill_err, flush_done},
               cache_wdata, cache_waddr, miss_ready);
    end
    rvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    drive_refill(32'h0000_9abc, 128'h00000004_00000003_00000002_00000001, -1, 0, 0, -1,
                 lat, extra, ar, ok);
    total++;
    if (lat !== 2 + BEATS || ar !== 32'h0000_9ab0) begin
      bad++;
      $display("FAIL refill_after_reset got lat=%0d araddr=%h want %0d 00009ab0",
               lat, ar, 2 + BEATS);
    end
  endtask

  task automatic test_queues_drained(input string name);
    @(negedge aclk);
    total++;
    if (wq.size() != 0 || fq.size() != 0) begin
      bad++;
      $display("FAIL %s leftover got writes=%0d fills=%0d want 0 0", name, wq.size(), fq.size());
    end
    wq.delete();
    fq.delete();
  endtask

  initial begin
    test_reset();
    test_refill_basic();
    test_queues_drained("refill_basic");
    test_backpressure();
    test_queues_drained("backpressure");
    test_error();
    test_queues_drained("error");
    test_foreign_id();
    test_queues_drained("foreign_id");
    test_flush_idle();
    test_queues_drained("flush_idle");
    test_flush_during_fill();
    test_queues_drained("flush_during_fill");
    test_async_reset_mid();
    test_queues_drained("async_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
